spin_angle_gen: RTL and testbench

- Generates the 4-bit paddle/spinner angle fed to the MCR1 game core's input_1 low nibble (Kick), directly upstream of the core input mux.
- Merges two sources into one wrapping angle counter, clocked in the system clock domain:
  - digital left/right/fast buttons, stepped once per video frame;
  - HPS analog spinner deltas, scaled by a power-of-two divider with fractional carry.

---
 rtl/spin_angle_gen.sv | 70 +++++++
 tb/tb_spin_angle_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spin_angle_gen.sv
// spin_angle_gen: merges frame-stepped button rotation and scaled HPS spinner deltas
// into one wrapping W-bit angle for the core's Kick input.
module spin_angle_gen #(
  parameter int W          = 4,
  parameter int STEP_SLOW  = 8,
  parameter int STEP_FAST  = 2,
  parameter int SPIN_SHIFT = 2
)(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         minus,
  input  logic         plus,
  input  logic         fast,
  input  logic         strobe,
  input  logic [8:0]   spin_in,
  output logic [W-1:0] spin_out
);
  localparam int SW = 9 + SPIN_SHIFT;
  localparam int CW = $clog2((STEP_SLOW > STEP_FAST ? STEP_SLOW : STEP_FAST) + 1);
  typedef enum logic {IDLE, HELD} state_t;
  state_t                state;
  logic [2:0]            strobe_q;
  logic [8:0]            spin_q;
  logic                  prev_tgl, armed;
  logic [SPIN_SHIFT-1:0] frac;
  logic [CW-1:0]         rep_cnt, period;
  logic                  tick, dir, spin_ev, btn_ev;
  logic [SW-1:0]         sum;
  logic [W-1:0]          d_btn, d_spin;
  always_comb begin
    tick    = strobe_q[1] & ~strobe_q[2];
    dir     = plus ^ minus;
    period  = fast ? CW'(STEP_FAST) : CW'(STEP_SLOW);
    btn_ev  = tick & dir & (state == IDLE || rep_cnt >= period - 1'b1);
    d_btn   = btn_ev ? (plus ? W'(1) : '1) : '0;
    spin_ev = armed & (spin_q[8] != prev_tgl);
    sum     = {{(SW-8){spin_q[7]}}, spin_q[7:0]} + {{(SW-SPIN_SHIFT){1'b0}}, frac};
    d_spin  = spin_ev ? W'(sum >> SPIN_SHIFT) : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= '0;
      spin_q   <= '0;
      prev_tgl <= 1'b0;
      armed    <= 1'b0;
      frac     <= '0;
      rep_cnt  <= '0;
      state    <= IDLE;
      spin_out <= '0;
    end else begin
      strobe_q <= {strobe_q[1:0], strobe};
      spin_q   <= spin_in;
      armed    <= 1'b1;
      // while arming, spin_q still holds its reset value; take the toggle it is about to load
      prev_tgl <= armed ? spin_q[8] : spin_in[8];
      if (spin_ev) frac <= sum[SPIN_SHIFT-1:0];
      if (tick) begin
        if (!dir) begin
          state   <= IDLE;
          rep_cnt <= '0;
        end else if (btn_ev) begin
          state   <= HELD;
          rep_cnt <= '0;
        end else
          rep_cnt <= rep_cnt + 1'b1;
      end
      spin_out <= spin_out + d_btn + d_spin;
    end
  end
endmodule

// File: tb/tb_spin_angle_gen.sv
// tb_spin_angle_gen: scoreboard bench for spin_angle_gen (W=4, STEP_SLOW=8, STEP_FAST=2, SPIN_SHIFT=2).
module tb_spin_angle_gen;
  logic       clk = 0, reset_n = 0, minus = 0, plus = 0, fast = 0, strobe = 0;
  logic [8:0] spin_in = '0;
  logic [3:0] spin_out;
  typedef struct packed {logic [3:0] out; logic [1:0] frac;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int   checks = 0, passed = 0;
  int   m_out, m_frac, m_rep;
  bit   m_held, tgl;

  spin_angle_gen dut (
    .clk(clk), .reset_n(reset_n), .minus(minus), .plus(plus), .fast(fast),
    .strobe(strobe), .spin_in(spin_in), .spin_out(spin_out)
  );

  always #5 clk = ~clk;

  task automatic push_exp();
    exp_q.push_back('{out: 4'(m_out), frac: 2'(m_frac)});
  endtask

  task automatic do_reset();
    reset_n = 0; plus = 0; minus = 0; fast = 0; strobe = 0;
    tgl = 1; spin_in = 9'h107;
    m_out = 0; m_frac = 0; m_rep = 0; m_held = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic spin_step(input logic [7:0] delta, input string name);
    int t, d;
    @(negedge clk);
    tgl = ~tgl;
    spin_in = {tgl, delta};
    t = m_frac + int'($signed(delta));
    d = (t >= 0) ? t / 4 : -((-t + 3) / 4);
    m_frac = t - 4 * d;
    m_out = (m_out + d) & 15;
    push_exp();
    repeat (2) @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (spin_out !== e.out) $display("FAIL %s spin_out got %0d want %0d", name, spin_out, e.out);
    else passed++;
    checks++;
    if (dut.frac !== e.frac) $display("FAIL %s frac got %0d want %0d", name, dut.frac, e.frac);
    else passed++;
  endtask

  task automatic frame_tick(input string name);
    @(negedge clk) strobe = 1;
    if (plus ^ minus) begin
      if (!m_held || m_rep >= (fast ? 2 : 8) - 1) begin
        m_out = (m_out + (plus ? 1 : -1)) & 15;
        m_rep = 0;
        m_held = 1;
      end else m_rep++;
    end else begin
      m_held = 0;
      m_rep = 0;
    end
    push_exp();
    repeat (3) @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (spin_out !== e.out) $display("FAIL %s spin_out got %0d want %0d", name, spin_out, e.out);
    else passed++;
    strobe = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 0; tgl = 1; spin_in = 9'h107;
    #1;
    checks++;
    if (spin_out !== 4'd0) $display("FAIL reset_hold spin_out got %0d want 0", spin_out);
    else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1;
    m_out = 0; m_frac = 0; m_rep = 0; m_held = 0;
    push_exp();
    repeat (10) @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (spin_out !== e.out) $display("FAIL reset_arm spin_out got %0d want %0d", spin_out, e.out);
    else passed++;
    checks++;
    if (dut.frac !== e.frac) $display("FAIL reset_arm frac got %0d want %0d", dut.frac, e.frac);
    else passed++;
  endtask

  task automatic test_spin_scale();
    do_reset();
    spin_step(8'd5, "spin_p5");
    spin_step(8'd3, "spin_p3");
    spin_step(8'hFF, "spin_m1");
    checks++;
    if (spin_out !== 4'd1 || dut.frac !== 2'd3)
      $display("FAIL spin_final got out=%0d frac=%0d want out=1 frac=3", spin_out, dut.frac);
    else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    spin_step(8'hFC, "wrap_m4");
    spin_step(8'd8, "wrap_p8");
    checks++;
    if (spin_out !== 4'd1) $display("FAIL wrap_const spin_out got %0d want 1", spin_out);
    else passed++;
    spin_step(8'd127, "wrap_big");
    spin_step(8'h80, "wrap_neg_big");
  endtask

  task automatic test_slow_repeat();
    do_reset();
    plus = 1;
    for (int i = 1; i <= 17; i++) frame_tick($sformatf("slow_tick%0d", i));
    checks++;
    if (spin_out !== 4'd3) $display("FAIL slow_const spin_out got %0d want 3", spin_out);
    else passed++;
    plus = 0;
    frame_tick("slow_release");
    plus = 1;
    frame_tick("slow_repress");
    plus = 0;
  endtask

  task automatic test_fast_both();
    do_reset();
    minus = 1; fast = 1;
    for (int i = 1; i <= 5; i++) frame_tick($sformatf("fast_tick%0d", i));
    checks++;
    if (spin_out !== 4'd13) $display("FAIL fast_const spin_out got %0d want 13", spin_out);
    else passed++;
    plus = 1;
    frame_tick("both_held");
    plus = 0; fast = 0;
    frame_tick("after_both");
    minus = 0;
  endtask

  task automatic test_fast_change_reversal();
    do_reset();
    plus = 1;
    for (int i = 1; i <= 4; i++) frame_tick($sformatf("chg_slow%0d", i));
    fast = 1;
    frame_tick("chg_fast_now");
    fast = 0;
    frame_tick("rev_plus");
    plus = 0; minus = 1;
    for (int i = 1; i <= 7; i++) frame_tick($sformatf("rev_minus%0d", i));
    minus = 0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    spin_step(8'hF8, "sim_to14");
    plus = 1;
    @(negedge clk) strobe = 1;
    @(negedge clk);
    tgl = ~tgl;
    spin_in = {tgl, 8'd4};
    m_out = (m_out + 1 + 1) & 15;
    m_held = 1; m_rep = 0;
    push_exp();
    repeat (2) @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (spin_out !== e.out || spin_out !== 4'd0) $display("FAIL simultaneous spin_out got %0d want 0", spin_out);
    else passed++;
    strobe = 0;
    repeat (3) @(negedge clk);
    spin_step(8'd4, "sim_pre_reset");
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    checks++;
    if (spin_out !== 4'd0) $display("FAIL async_reset spin_out got %0d want 0", spin_out);
    else passed++;
    plus = 0;
    @(negedge clk) reset_n = 1;
  endtask

  initial begin
    test_reset();
    test_spin_scale();
    test_wrap();
    test_slow_repeat();
    test_fast_both();
    test_fast_change_reversal();
    test_simultaneous();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
